// File: rtl/bus_master_if_pkg.sv
// Shared types and encodings for the requester-side bus master interface.
package bus_master_if_pkg;

    typedef enum logic [1:0] {
        BUS_MST_IDLE   = 2'd0,
        BUS_MST_REQ    = 2'd1,
        BUS_MST_ACCESS = 2'd2,
        BUS_MST_WAIT   = 2'd3
    } bus_mst_state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/bus_master_if_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags the final allowed cycle.
module bus_watchdog #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned TIMEOUT_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] count;

    // Saturates at LAST so a held enable never wraps back into range.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/bus_master_if.sv
// Requester-side bus interface: arbitration handshake, single transfers, bus lock, watchdog abort.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned TIMEOUT_W = 5
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              core_req,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic              core_lock,
    output logic              core_busy,
    output logic              core_rdy,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              m_req,
    input  logic              m_grnt,
    output logic              m_as,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_rdy
);

    bus_mst_state_t state;
    logic           on_bus;
    logic           expired;

    assign on_bus = (state == BUS_MST_ACCESS) || (state == BUS_MST_WAIT);

    // Held clear outside ACCESS/WAIT, so the count is zero on every entry to ACCESS.
    bus_watchdog #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rest),
        .clear   (!on_bus),
        .enable  (on_bus),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rest) begin
            state        <= BUS_MST_IDLE;
            core_busy    <= 1'b0;
            core_rdy     <= 1'b0;
            core_err     <= 1'b0;
            core_rd_data <= '0;
            m_req        <= 1'b0;
            m_as         <= 1'b0;
            m_rw         <= READ;
            m_addr       <= '0;
            m_wr_data    <= '0;
        end else begin
            core_rdy <= 1'b0;
            core_err <= 1'b0;
            case (state)
                BUS_MST_IDLE: begin
                    if (core_req) begin
                        m_rw      <= core_rw;
                        m_addr    <= core_addr;
                        m_wr_data <= core_wr_data;
                        core_busy <= 1'b1;
                        // Still owning the bus from a locked transfer: skip arbitration.
                        if (m_req && m_grnt) begin
                            m_as  <= 1'b1;
                            state <= BUS_MST_ACCESS;
                        end else begin
                            m_req <= 1'b1;
                            state <= BUS_MST_REQ;
                        end
                    end else if (!core_lock && m_req) begin
                        m_req <= 1'b0;
                    end
                end
                BUS_MST_REQ: begin
                    if (m_grnt) begin
                        m_as  <= 1'b1;
                        state <= BUS_MST_ACCESS;
                    end
                end
                BUS_MST_ACCESS, BUS_MST_WAIT: begin
                    m_as  <= 1'b0;
                    state <= BUS_MST_WAIT;
                    // A late s_rdy still beats the watchdog; a lost grant always aborts.
                    if (!m_grnt || (!s_rdy && expired)) begin
                        core_rdy     <= 1'b1;
                        core_err     <= 1'b1;
                        core_rd_data <= '0;
                        core_busy    <= 1'b0;
                        m_req        <= 1'b0;
                        state        <= BUS_MST_IDLE;
                    end else if (s_rdy) begin
                        core_rdy  <= 1'b1;
                        core_busy <= 1'b0;
                        m_req     <= core_lock;
                        if (m_rw == READ) begin
                            core_rd_data <= s_rd_data;
                        end
                        state <= BUS_MST_IDLE;
                    end
                end
                default: state <= BUS_MST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed self-checking bench for bus_master_if; the bench plays arbiter and slave.
module tb_bus_master_if;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rest;
    logic              core_req;
    logic              core_rw;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_lock;
    logic              core_busy;
    logic              core_rdy;
    logic              core_err;
    logic [DATA_W-1:0] core_rd_data;
    logic              m_req;
    logic              m_grnt;
    logic              m_as;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic [DATA_W-1:0] s_rd_data;
    logic              s_rdy;

    int unsigned passed = 0;
    int unsigned total  = 0;

    bus_master_if #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TIMEOUT   (4),
        .TIMEOUT_W (5)
    ) dut (
        .clk          (clk),
        .rest         (rest),
        .core_req     (core_req),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_lock    (core_lock),
        .core_busy    (core_busy),
        .core_rdy     (core_rdy),
        .core_err     (core_err),
        .core_rd_data (core_rd_data),
        .m_req        (m_req),
        .m_grnt       (m_grnt),
        .m_as         (m_as),
        .m_rw         (m_rw),
        .m_addr       (m_addr),
        .m_wr_data    (m_wr_data),
        .s_rd_data    (s_rd_data),
        .s_rdy        (s_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        core_req     = 1'b1;
        core_rw      = rw;
        core_addr    = addr;
        core_wr_data = wd;
    endtask

    initial begin
        rest = 1'b1; core_req = 1'b0; core_rw = 1'b1; core_addr = '0; core_wr_data = '0;
        core_lock = 1'b0; m_grnt = 1'b1; s_rd_data = '0; s_rdy = 1'b0;
        tick(); tick();
        chk("rst_m_req",   64'(m_req), 64'd0);
        chk("rst_m_as",    64'(m_as), 64'd0);
        chk("rst_busy",    64'(core_busy), 64'd0);
        chk("rst_rdy",     64'(core_rdy), 64'd0);
        chk("rst_m_rw",    64'(m_rw), 64'd1);
        chk("rst_rd_data", 64'(core_rd_data), 64'd0);
        rest = 1'b0;
        tick();
        chk("idle_grant_ignored", 64'(m_req), 64'd0);

        // Default owner after reset, zero-wait write.
        start(1'b0, 30'h004, 32'h1234_5678);
        s_rdy = 1'b1;
        tick();
        core_req = 1'b0;
        chk("t2_m_req",  64'(m_req), 64'd1);
        chk("t2_busy",   64'(core_busy), 64'd1);
        chk("t2_as_lo",  64'(m_as), 64'd0);
        tick();
        chk("t2_m_as",   64'(m_as), 64'd1);
        chk("t2_wdata",  64'(m_wr_data), 64'h1234_5678);
        chk("t2_m_rw",   64'(m_rw), 64'd0);
        tick();
        chk("t2_rdy",    64'(core_rdy), 64'd1);
        chk("t2_err",    64'(core_err), 64'd0);
        chk("t2_wdata2", 64'(m_wr_data), 64'h1234_5678);
        chk("t2_rdata",  64'(core_rd_data), 64'd0);
        chk("t2_m_req0", 64'(m_req), 64'd0);
        chk("t2_busy0",  64'(core_busy), 64'd0);
        s_rdy = 1'b0; m_grnt = 1'b0;
        tick();
        chk("t2_rdy_pulse", 64'(core_rdy), 64'd0);

        // Arbitrated read, slave ready two cycles after the strobe.
        start(1'b1, 30'h100, 32'h0);
        tick();
        core_req = 1'b0;
        chk("t1_m_req", 64'(m_req), 64'd1);
        tick();
        chk("t1_no_as", 64'(m_as), 64'd0);
        m_grnt = 1'b1;
        tick();
        chk("t1_m_as",  64'(m_as), 64'd1);
        chk("t1_addr",  64'(m_addr), 64'h100);
        tick();
        chk("t1_as_drop", 64'(m_as), 64'd0);
        chk("t1_no_rdy",  64'(core_rdy), 64'd0);
        s_rdy = 1'b1; s_rd_data = 32'hDEAD_BEEF;
        tick();
        chk("t1_rdy",   64'(core_rdy), 64'd1);
        chk("t1_rdata", 64'(core_rd_data), 64'hDEAD_BEEF);
        chk("t1_m_req0", 64'(m_req), 64'd0);
        s_rdy = 1'b0; m_grnt = 1'b0;
        tick();

        // Locked back-to-back reads.
        core_lock = 1'b1;
        start(1'b1, 30'h200, 32'h0);
        tick();
        core_req = 1'b0; m_grnt = 1'b1;
        tick();
        chk("t3_as1", 64'(m_as), 64'd1);
        s_rdy = 1'b1; s_rd_data = 32'hA5A5_A5A5;
        tick();
        chk("t3_rdy1",  64'(core_rdy), 64'd1);
        chk("t3_data1", 64'(core_rd_data), 64'hA5A5_A5A5);
        chk("t3_held1", 64'(m_req), 64'd1);
        s_rdy = 1'b0;
        tick();
        chk("t3_held2", 64'(m_req), 64'd1);
        start(1'b1, 30'h204, 32'h0);
        tick();
        core_req = 1'b0;
        chk("t3_as2",   64'(m_as), 64'd1);
        chk("t3_addr2", 64'(m_addr), 64'h204);
        chk("t3_held3", 64'(m_req), 64'd1);
        s_rdy = 1'b1; s_rd_data = 32'h0BAD_F00D;
        tick();
        chk("t3_rdy2",  64'(core_rdy), 64'd1);
        chk("t3_data2", 64'(core_rd_data), 64'h0BAD_F00D);
        chk("t3_held4", 64'(m_req), 64'd1);
        s_rdy = 1'b0; core_lock = 1'b0;
        tick();
        chk("t3_release", 64'(m_req), 64'd0);
        m_grnt = 1'b0;

        // Silent slave: abort four cycles after the strobe.
        start(1'b1, 30'h300, 32'h0);
        tick();
        core_req = 1'b0; m_grnt = 1'b1;
        tick();
        chk("t4_as", 64'(m_as), 64'd1);
        tick(); tick(); tick();
        chk("t4_not_yet", 64'(core_rdy), 64'd0);
        tick();
        chk("t4_rdy",   64'(core_rdy), 64'd1);
        chk("t4_err",   64'(core_err), 64'd1);
        chk("t4_rdata", 64'(core_rd_data), 64'd0);
        chk("t4_m_req", 64'(m_req), 64'd0);
        tick();
        chk("t4_err_pulse", 64'(core_err), 64'd0);
        m_grnt = 1'b0;

        // s_rdy on the final watchdog cycle wins.
        start(1'b1, 30'h304, 32'h0);
        tick();
        core_req = 1'b0; m_grnt = 1'b1;
        tick(); tick(); tick(); tick();
        s_rdy = 1'b1; s_rd_data = 32'h55AA_55AA;
        tick();
        chk("t5_rdy",   64'(core_rdy), 64'd1);
        chk("t5_err",   64'(core_err), 64'd0);
        chk("t5_rdata", 64'(core_rd_data), 64'h55AA_55AA);
        s_rdy = 1'b0; m_grnt = 1'b0;
        tick();

        // Grant lost while waiting.
        start(1'b1, 30'h308, 32'h0);
        tick();
        core_req = 1'b0; m_grnt = 1'b1;
        tick(); tick();
        m_grnt = 1'b0;
        tick();
        chk("t5_gl_rdy",   64'(core_rdy), 64'd1);
        chk("t5_gl_err",   64'(core_err), 64'd1);
        chk("t5_gl_m_req", 64'(m_req), 64'd0);
        tick();

        // Reset mid-transaction.
        start(1'b1, 30'h30C, 32'h0);
        tick();
        core_req = 1'b0; m_grnt = 1'b1;
        tick(); tick();
        rest = 1'b1;
        tick();
        chk("t6_rst_m_req", 64'(m_req), 64'd0);
        chk("t6_rst_as",    64'(m_as), 64'd0);
        chk("t6_rst_rdy",   64'(core_rdy), 64'd0);
        chk("t6_rst_busy",  64'(core_busy), 64'd0);
        rest = 1'b0; s_rdy = 1'b1;
        tick();
        chk("t6_no_rdy", 64'(core_rdy), 64'd0);
        s_rdy = 1'b0; m_grnt = 1'b0;

        // core_req while busy is ignored.
        start(1'b1, 30'h400, 32'h0);
        tick();
        core_addr = 30'h500; m_grnt = 1'b1;
        tick();
        chk("t6_as",    64'(m_as), 64'd1);
        chk("t6_addr1", 64'(m_addr), 64'h400);
        tick();
        chk("t6_addr2", 64'(m_addr), 64'h400);
        core_req = 1'b0; s_rdy = 1'b1; s_rd_data = 32'h1111_2222;
        tick();
        chk("t6_rdy",   64'(core_rdy), 64'd1);
        chk("t6_rdata", 64'(core_rd_data), 64'h1111_2222);
        chk("t6_addr3", 64'(m_addr), 64'h400);
        s_rdy = 1'b0;
        tick();
        chk("t6_idle_busy", 64'(core_busy), 64'd0);
        chk("t6_idle_req",  64'(m_req), 64'd0);
        chk("t6_idle_as",   64'(m_as), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
